// File: rtl/codec_seq.sv
// I2C register-write sequencer: walks a configuration table and issues each
// entry as one multi-byte write through the TWICtl byte-level controller.
module codec_seq #(
    parameter logic [6:0] DEV_ADDR  = 7'h3B,
    parameter int         N_ENTRIES = 35,
    parameter int         REG_BYTES = 2,
    parameter int         MAX_DATA  = 6,
    parameter int         DELAY_CYC = 24000,
    parameter int         MAX_RETRY = 3,
    parameter int         TAW       = $clog2(N_ENTRIES),
    parameter int         EW        = 4 + 8*REG_BYTES + 8*MAX_DATA
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [TAW-1:0] tbl_addr,
    input  logic [EW-1:0]  tbl_data,
    output logic           twi_msg,
    output logic           twi_stb,
    output logic [7:0]     twi_addr,
    output logic [7:0]     twi_d,
    input  logic           twi_done,
    input  logic           twi_err,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic [TAW-1:0] fail_idx,
    output logic [7:0]     retries
);

    localparam int RW = 8*REG_BYTES;
    localparam int DW = 8*MAX_DATA;
    localparam int CW = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam logic [TAW-1:0] LAST = TAW'(N_ENTRIES-1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, GAP, DONE, FAIL} state_t;

    state_t         state_q, state_n;
    logic [TAW-1:0] idx_q, idx_n, tbl_addr_n, fail_idx_n;
    logic [3:0]     bc_q, bc_n, rc_q, rc_n, len_q, len_n;
    logic [RW-1:0]  reg_q, reg_n;
    logic [DW-1:0]  data_q, data_n;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic           new_q, new_n, gap_req;
    logic           msg_n, stb_n, busy_n, done_n, fail_n;
    logic [7:0]     d_n, retries_n;
    logic [3:0]     ld_len, ld_len_clamped, bc_inc;
    logic           ent_end;

    // Byte b of the wire stream: register bytes MSB first, then data from the top.
    function automatic logic [7:0] stream_byte(input logic [RW-1:0] r,
                                               input logic [DW-1:0] d,
                                               input logic [3:0]    b);
        logic [RW-1:0] rs;
        logic [DW-1:0] ds;
        int            k;
        rs = '0;
        ds = '0;
        k  = int'(b);
        stream_byte = 8'h00;
        if (k < REG_BYTES) begin
            rs = r >> (8*(REG_BYTES-1-k));
            stream_byte = rs[7:0];
        end else if (k < REG_BYTES + MAX_DATA) begin
            ds = d >> (8*(MAX_DATA-1-(k-REG_BYTES)));
            stream_byte = ds[7:0];
        end
    endfunction

    assign twi_addr       = {DEV_ADDR, 1'b0};
    assign ld_len         = tbl_data[EW-1 -: 4];
    assign ld_len_clamped = (ld_len > 4'(MAX_DATA)) ? 4'(MAX_DATA) : ld_len;
    assign bc_inc         = bc_q + 4'd1;
    assign ent_end        = (bc_inc == 4'(REG_BYTES) + len_q);

    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        bc_n       = bc_q;
        rc_n       = rc_q;
        len_n      = len_q;
        reg_n      = reg_q;
        data_n     = data_q;
        cnt_n      = cnt_q;
        new_n      = new_q;
        gap_req    = 1'b0;
        tbl_addr_n = tbl_addr;
        fail_idx_n = fail_idx;
        msg_n      = twi_msg;
        stb_n      = twi_stb;
        d_n        = twi_d;
        busy_n     = busy;
        done_n     = done;
        fail_n     = fail;
        retries_n  = retries;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_n   = FETCH;
                    idx_n     = '0;
                    retries_n = 8'h00;
                    done_n    = 1'b0;
                    fail_n    = 1'b0;
                    busy_n    = 1'b1;
                    new_n     = 1'b1;
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                len_n  = ld_len_clamped;
                reg_n  = tbl_data[DW +: RW];
                data_n = tbl_data[DW-1:0];
                bc_n   = 4'd0;
                if (new_q) begin
                    rc_n  = 4'd0;
                    new_n = 1'b0;
                end
                if (ld_len == 4'd0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    state_n = SEND;
                    stb_n   = 1'b1;
                    msg_n   = 1'b1;
                    d_n     = stream_byte(tbl_data[DW +: RW], tbl_data[DW-1:0], 4'd0);
                end
            end
            SEND: begin
                if (twi_done && !twi_err) begin
                    bc_n  = bc_inc;
                    msg_n = 1'b0;
                    if (ent_end) begin
                        stb_n = 1'b0;
                        if (idx_q == LAST) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                        end else begin
                            idx_n   = idx_q + TAW'(1);
                            new_n   = 1'b1;
                            gap_req = 1'b1;
                        end
                    end else begin
                        d_n = stream_byte(reg_q, data_q, bc_inc);
                    end
                end else if (twi_done) begin
                    stb_n = 1'b0;
                    msg_n = 1'b0;
                    if (rc_q < 4'(MAX_RETRY)) begin
                        rc_n    = rc_q + 4'd1;
                        bc_n    = 4'd0;
                        gap_req = 1'b1;
                        if (retries != 8'hFF) retries_n = retries + 8'd1;
                    end else begin
                        fail_idx_n = idx_q;
                        state_n    = FAIL;
                        fail_n     = 1'b1;
                        busy_n     = 1'b0;
                    end
                end
            end
            GAP: begin
                if (cnt_q == CW'(DELAY_CYC-1)) state_n = FETCH;
                else                           cnt_n   = cnt_q + CW'(1);
            end
            default: state_n = IDLE;
        endcase
        if (gap_req) begin
            if (DELAY_CYC == 0) begin
                state_n = FETCH;
            end else begin
                state_n = GAP;
                cnt_n   = '0;
            end
        end
        if (state_n == FETCH) tbl_addr_n = idx_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            bc_q     <= 4'd0;
            rc_q     <= 4'd0;
            len_q    <= 4'd0;
            reg_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            new_q    <= 1'b0;
            tbl_addr <= '0;
            fail_idx <= '0;
            twi_msg  <= 1'b0;
            twi_stb  <= 1'b0;
            twi_d    <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            retries  <= 8'h00;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            bc_q     <= bc_n;
            rc_q     <= rc_n;
            len_q    <= len_n;
            reg_q    <= reg_n;
            data_q   <= data_n;
            cnt_q    <= cnt_n;
            new_q    <= new_n;
            tbl_addr <= tbl_addr_n;
            fail_idx <= fail_idx_n;
            twi_msg  <= msg_n;
            twi_stb  <= stb_n;
            twi_d    <= d_n;
            busy     <= busy_n;
            done     <= done_n;
            fail     <= fail_n;
            retries  <= retries_n;
        end
    end

endmodule

// File: tb/tb_codec_seq.sv
// Directed bench for codec_seq: 3-entry table, behavioural TWICtl with
// per-byte error injection and a synchronous table ROM.
module tb_codec_seq;

    localparam int EW = 68;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    tbl_addr;
    logic [EW-1:0] tbl_data = '0;
    logic          twi_msg, twi_stb, twi_done = 1'b0, twi_err = 1'b0;
    logic [7:0]    twi_addr, twi_d, retries;
    logic          busy, done, fail;
    logic [1:0]    fail_idx;

    logic [EW-1:0] tbl [3];
    logic [7:0]    byte_q [$];
    logic          msg_q  [$];
    int            n_checks = 0, n_fail = 0;
    int            lat = 0, pos = 0, cur_pos = 0, att1 = 0;
    int            err_entry = -1, err_byte = -1, err_left = 0;
    logic [1:0]    max_addr = 2'd0;
    int            cyc, cnt;

    logic [7:0] exp_norm [16] = '{8'h40, 8'h15, 8'h01, 8'h40, 8'h16, 8'h00, 8'h40, 8'h02,
                                  8'h00, 8'h7D, 8'h00, 8'h0C, 8'h21, 8'h01, 8'h00, 8'h00};
    logic [7:0] exp_retry [16] = '{8'h40, 8'h15, 8'h01, 8'h40, 8'h16, 8'h40, 8'h16, 8'h00,
                                   8'h40, 8'h02, 8'h00, 8'h7D, 8'h00, 8'h0C, 8'h21, 8'h01};

    codec_seq #(
        .DEV_ADDR(7'h3B), .N_ENTRIES(3), .REG_BYTES(2), .MAX_DATA(6),
        .DELAY_CYC(4), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .twi_msg(twi_msg), .twi_stb(twi_stb), .twi_addr(twi_addr), .twi_d(twi_d),
        .twi_done(twi_done), .twi_err(twi_err), .busy(busy), .done(done), .fail(fail),
        .fail_idx(fail_idx), .retries(retries)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    // TWICtl stand-in: acknowledges each byte two cycles after it is strobed.
    always @(negedge clk) begin
        twi_done = 1'b0;
        twi_err  = 1'b0;
        if (rst || !twi_stb) begin
            lat = 0;
        end else begin
            lat++;
            if (lat == 2) begin
                lat     = 0;
                cur_pos = twi_msg ? 0 : pos;
                twi_done = 1'b1;
                if (err_left > 0 && int'(tbl_addr) == err_entry && cur_pos == err_byte) begin
                    twi_err = 1'b1;
                    err_left--;
                end
                byte_q.push_back(twi_d);
                msg_q.push_back(twi_msg);
                if (twi_msg && tbl_addr == 2'd1) att1++;
                pos = cur_pos + 1;
            end
        end
        if (busy && tbl_addr > max_addr) max_addr = tbl_addr;
    end

    task automatic clear_run();
        byte_q.delete();
        msg_q.delete();
        att1 = 0;
        max_addr = 2'd0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        cnt = 0;
        while (busy && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (busy) begin
            $display("[TB] FAIL %s_timeout: busy still %0b after %0d cycles, required 0", tag, busy, cnt);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({busy, done, fail} !== 3'b000) begin $display("[TB] FAIL reset_flags: busy/done/fail %b, required 000", {busy, done, fail}); n_fail++; end
        n_checks++; if ({twi_stb, twi_msg} !== 2'b00) begin $display("[TB] FAIL reset_stb_msg: %b, required 00", {twi_stb, twi_msg}); n_fail++; end
        n_checks++; if (twi_d !== 8'h00) begin $display("[TB] FAIL reset_twi_d: %h, required 00", twi_d); n_fail++; end
        n_checks++; if ({tbl_addr, fail_idx, retries} !== 12'h000) begin $display("[TB] FAIL reset_counters: %h, required 000", {tbl_addr, fail_idx, retries}); n_fail++; end
        n_checks++; if (twi_addr !== 8'h76) begin $display("[TB] FAIL twi_addr: %h, required 76", twi_addr); n_fail++; end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        clear_run();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin $display("[TB] FAIL start_busy: %b, required 1", busy); n_fail++; end
        cyc = 1;
        while (!twi_stb && cyc < 10) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (cyc != 3) begin $display("[TB] FAIL start_latency: stb after %0d edges, required 3", cyc); n_fail++; end
        wait_idle("normal");
        n_checks++; if (byte_q.size() != 14) begin $display("[TB] FAIL normal_len: %0d bytes, required 14", byte_q.size()); n_fail++; end
        for (int i = 0; i < 14 && i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] !== exp_norm[i] || msg_q[i] !== (i == 0 || i == 3 || i == 6)) begin
                $display("[TB] FAIL normal_byte%0d: %h msg %b, required %h msg %b", i, byte_q[i], msg_q[i], exp_norm[i], (i == 0 || i == 3 || i == 6));
                n_fail++;
            end
        end
        n_checks++; if ({done, fail, busy} !== 3'b100 || retries !== 8'd0) begin $display("[TB] FAIL normal_status: done/fail/busy %b retries %0d, required 100 / 0", {done, fail, busy}, retries); n_fail++; end
        n_checks++; if (max_addr !== 2'd2) begin $display("[TB] FAIL normal_max_addr: %0d, required 2", max_addr); n_fail++; end
    endtask

    task automatic test_retry();
        clear_run();
        err_entry = 1; err_byte = 1; err_left = 1;
        pulse_start();
        wait_idle("retry");
        n_checks++; if (byte_q.size() != 16) begin $display("[TB] FAIL retry_len: %0d bytes, required 16", byte_q.size()); n_fail++; end
        for (int i = 0; i < 16 && i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] !== exp_retry[i] || msg_q[i] !== (i == 0 || i == 3 || i == 5 || i == 8)) begin
                $display("[TB] FAIL retry_byte%0d: %h msg %b, required %h msg %b", i, byte_q[i], msg_q[i], exp_retry[i], (i == 0 || i == 3 || i == 5 || i == 8));
                n_fail++;
            end
        end
        n_checks++; if ({done, fail} !== 2'b10 || retries !== 8'd1) begin $display("[TB] FAIL retry_status: done/fail %b retries %0d, required 10 / 1", {done, fail}, retries); n_fail++; end
        err_left = 0;
    endtask

    task automatic test_exhaust();
        clear_run();
        err_entry = 1; err_byte = 1; err_left = 100;
        pulse_start();
        wait_idle("exhaust");
        n_checks++; if (att1 != 3) begin $display("[TB] FAIL exhaust_attempts: %0d, required 3", att1); n_fail++; end
        n_checks++; if ({done, fail, busy} !== 3'b010) begin $display("[TB] FAIL exhaust_flags: done/fail/busy %b, required 010", {done, fail, busy}); n_fail++; end
        n_checks++; if (fail_idx !== 2'd1 || retries !== 8'd2) begin $display("[TB] FAIL exhaust_idx: fail_idx %0d retries %0d, required 1 / 2", fail_idx, retries); n_fail++; end
        n_checks++; if (max_addr !== 2'd1 || byte_q.size() != 9) begin $display("[TB] FAIL exhaust_reach: max_addr %0d bytes %0d, required 1 / 9", max_addr, byte_q.size()); n_fail++; end
        err_left = 0;
    endtask

    task automatic test_terminator();
        clear_run();
        tbl[1] = {4'd0, 16'h4016, 48'h0};
        pulse_start();
        wait_idle("term");
        n_checks++; if ({done, fail} !== 2'b10 || retries !== 8'd0) begin $display("[TB] FAIL term_status: done/fail %b retries %0d, required 10 / 0", {done, fail}, retries); n_fail++; end
        n_checks++; if (max_addr !== 2'd1) begin $display("[TB] FAIL term_max_addr: %0d, required 1", max_addr); n_fail++; end
        n_checks++; if (byte_q.size() != 3) begin $display("[TB] FAIL term_len: %0d bytes, required 3", byte_q.size()); n_fail++; end
        tbl[1] = {4'd1, 16'h4016, 48'h00_0000000000};
    endtask

    task automatic test_async_reset();
        clear_run();
        pulse_start();
        cnt = 0;
        while (byte_q.size() < 8 && cnt < 3000) begin @(negedge clk); cnt++; end
        @(posedge clk); #1;
        n_checks++; if (twi_stb !== 1'b1 || twi_d !== 8'h00) begin $display("[TB] FAIL mid_pre: stb %b d %h, required 1 / 00", twi_stb, twi_d); n_fail++; end
        rst = 1'b1;
        #1;
        n_checks++; if ({twi_stb, busy, twi_d} !== 10'b0) begin $display("[TB] FAIL mid_async: stb/busy %b%b d %h, required 00 / 00", twi_stb, busy, twi_d); n_fail++; end
        @(negedge clk); rst = 1'b0;
        clear_run();
        pulse_start();
        wait_idle("replay");
        n_checks++; if (byte_q.size() != 14 || done !== 1'b1) begin $display("[TB] FAIL replay_len: %0d bytes done %b, required 14 / 1", byte_q.size(), done); n_fail++; end
        for (int i = 0; i < 14 && i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] !== exp_norm[i]) begin $display("[TB] FAIL replay_byte%0d: %h, required %h", i, byte_q[i], exp_norm[i]); n_fail++; end
        end
    endtask

    task automatic test_back_to_back();
        clear_run();
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle("b2b");
        n_checks++; if (byte_q.size() != 14 || done !== 1'b1) begin $display("[TB] FAIL b2b_len: %0d bytes done %b, required 14 / 1", byte_q.size(), done); n_fail++; end
        for (int i = 0; i < 14 && i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] !== exp_norm[i]) begin $display("[TB] FAIL b2b_byte%0d: %h, required %h", i, byte_q[i], exp_norm[i]); n_fail++; end
        end
        clear_run();
        pulse_start();
        n_checks++; if ({done, busy} !== 2'b01) begin $display("[TB] FAIL rerun_clear: done/busy %b, required 01", {done, busy}); n_fail++; end
        wait_idle("rerun");
        n_checks++; if (byte_q.size() != 14 || done !== 1'b1) begin $display("[TB] FAIL rerun_len: %0d bytes done %b, required 14 / 1", byte_q.size(), done); n_fail++; end
    endtask

    initial begin
        tbl[0] = {4'd1, 16'h4015, 48'h01_0000000000};
        tbl[1] = {4'd1, 16'h4016, 48'h00_0000000000};
        tbl[2] = {4'd6, 16'h4002, 48'h007D000C2101};
        test_reset();
        test_normal();
        test_retry();
        test_exhaust();
        test_terminator();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
